// File: rtl/id_ex_alu_feed.sv
// ---------------------------------------------------------------------------
// id_ex_alu_feed
//
// This block is the ID/EX pipeline register of the 5-stage RISC-V core. It
// also contains the operand-select logic that feeds the 64-bit ALU.
//
// What it does:
//   - Captures the decoded operands and controls coming from ID.
//   - Forwards results from EX/MEM and MEM/WB into the EX operands.
//   - Decodes the 4-bit ALU opcode.
//   - Detects load-use hazards and inserts a bubble when one occurs.
//
// Build option:
//   ID_EX_STALL_CNT_EN  when defined, stall_count is a free-running 32-bit
//                       count of hazard bubbles. When undefined, stall_count
//                       is tied to 0.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   id_*                    decoded instruction fields and controls from ID
//   stall_in                global pipeline hold
//   flush                   branch-taken squash of the EX stage
//   exmem_*, memwb_*        writer valid / index / data used for forwarding
//   alu_a, alu_b            ALU operands
//   alu_operation           ALU opcode
//   ex_store_data           forwarded rs2 value, used by stores
//   ex_*                    registered controls and destination index
//   hazard_stall            holds PC and IF/ID during a load-use hazard
//   stall_count             hazard bubble counter (see build option)
// ---------------------------------------------------------------------------
module id_ex_alu_feed #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [1:0]            id_alu_op,
    input  logic [2:0]            id_funct3,
    input  logic                  id_funct7_b5,
    input  logic                  id_alu_src,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  id_branch,
    input  logic                  stall_in,
    input  logic                  flush,
    input  logic                  exmem_reg_write,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic [XLEN-1:0]       memwb_result,
    output logic [XLEN-1:0]       alu_a,
    output logic [XLEN-1:0]       alu_b,
    output logic [3:0]            alu_operation,
    output logic [XLEN-1:0]       ex_store_data,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_branch,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  hazard_stall,
    output logic [31:0]           stall_count
);

    // Everything held in the EX stage. An all-zero value is a bubble: it is
    // invalid, it writes nothing, and it decodes as ADD of 0 + 0.
    typedef struct packed {
        logic                  valid;
        logic                  regWrite;
        logic                  memRead;
        logic                  memWrite;
        logic                  memToReg;
        logic                  branch;
        logic                  aluSrc;
        logic [1:0]            aluOp;
        logic [2:0]            funct3;
        logic                  funct7B5;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       rs1Data;
        logic [XLEN-1:0]       rs2Data;
        logic [XLEN-1:0]       imm;
    } stage_t;

    stage_t stage_q;
    stage_t stage_d;
    stage_t idStage;

    logic [XLEN-1:0] fwdRs1;
    logic [XLEN-1:0] fwdRs2;

    // Load-use hazard: a load in EX writes a register that the ID
    // instruction reads. rs2 only counts when ID actually uses it, that is,
    // when the immediate is not selected. A global hold masks the stall,
    // because nothing advances during a hold anyway.
    assign hazard_stall = ~stall_in & stage_q.valid & stage_q.memRead
                        & (stage_q.rd != '0) & id_valid
                        & ((stage_q.rd == id_rs1)
                           | ((stage_q.rd == id_rs2) & ~id_alu_src));

    // Gather the ID fields into the layout of the stage register.
    always_comb begin
        idStage          = '0;
        idStage.valid    = id_valid;
        idStage.regWrite = id_reg_write;
        idStage.memRead  = id_mem_read;
        idStage.memWrite = id_mem_write;
        idStage.memToReg = id_mem_to_reg;
        idStage.branch   = id_branch;
        idStage.aluSrc   = id_alu_src;
        idStage.aluOp    = id_alu_op;
        idStage.funct3   = id_funct3;
        idStage.funct7B5 = id_funct7_b5;
        idStage.rs1      = id_rs1;
        idStage.rs2      = id_rs2;
        idStage.rd       = id_rd;
        idStage.rs1Data  = id_rs1_data;
        idStage.rs2Data  = id_rs2_data;
        idStage.imm      = id_imm;
    end

    // Next-state selection, in priority order (reset is handled in the flop):
    //   1. flush squashes EX.
    //   2. A hold keeps the current contents.
    //   3. A load-use hazard inserts a bubble.
    //   4. Otherwise ID advances into EX.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (stall_in) begin
            stage_d = stage_q;
        end else if (hazard_stall) begin
            stage_d = '0;
        end else begin
            stage_d = idStage;
        end
    end

    // Stage register with synchronous reset. Reset overrides a hold, so the
    // stage is empty on the cycle after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Operand forwarding. EX/MEM holds the younger result, so it wins over
    // MEM/WB. x0 is never forwarded because it is hard-wired to zero.
    always_comb begin
        fwdRs1 = stage_q.rs1Data;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == stage_q.rs1) begin
            fwdRs1 = exmem_result;
        end else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == stage_q.rs1) begin
            fwdRs1 = memwb_result;
        end

        fwdRs2 = stage_q.rs2Data;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == stage_q.rs2) begin
            fwdRs2 = exmem_result;
        end else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == stage_q.rs2) begin
            fwdRs2 = memwb_result;
        end
    end

    assign alu_a         = fwdRs1;
    assign alu_b         = stage_q.aluSrc ? stage_q.imm : fwdRs2;
    assign ex_store_data = fwdRs2;

    // ALU control decode.
    //   - Loads/stores compute an address with ADD.
    //   - Branches compare with SUB.
    //   - funct7 bit 5 selects SUB only for R-type; I-type ignores it.
    //   - Unsupported encodings map to 1111, for which the ALU returns 0.
    always_comb begin
        alu_operation = 4'b1111;
        case (stage_q.aluOp)
            2'b00: alu_operation = 4'b0010;
            2'b01: alu_operation = 4'b0110;
            2'b10: begin
                case (stage_q.funct3)
                    3'b000:  alu_operation = stage_q.funct7B5 ? 4'b0110 : 4'b0010;
                    3'b111:  alu_operation = 4'b0000;
                    3'b110:  alu_operation = 4'b0001;
                    3'b001:  alu_operation = 4'b1000;
                    default: alu_operation = 4'b1111;
                endcase
            end
            default: begin
                case (stage_q.funct3)
                    3'b000:  alu_operation = 4'b0010;
                    3'b111:  alu_operation = 4'b0000;
                    3'b110:  alu_operation = 4'b0001;
                    3'b001:  alu_operation = 4'b1000;
                    default: alu_operation = 4'b1111;
                endcase
            end
        endcase
    end

    assign ex_valid      = stage_q.valid;
    assign ex_reg_write  = stage_q.regWrite;
    assign ex_mem_read   = stage_q.memRead;
    assign ex_mem_write  = stage_q.memWrite;
    assign ex_mem_to_reg = stage_q.memToReg;
    assign ex_branch     = stage_q.branch;
    assign ex_rd         = stage_q.rd;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stallCount_q;
    logic [31:0] stallCount_d;

    // Count only the bubbles caused by hazards. When a flush and a hazard
    // occur on the same edge, the bubble belongs to the flush and is not
    // counted. The counter wraps naturally from 0xFFFFFFFF to 0.
    always_comb begin
        stallCount_d = stallCount_q;
        if (!flush && hazard_stall) begin
            stallCount_d = stallCount_q + 32'd1;
        end
    end

    // Counter register; it is cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount_q <= '0;
        end else begin
            stallCount_q <= stallCount_d;
        end
    end

    assign stall_count = stallCount_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_alu_feed.sv
// ---------------------------------------------------------------------------
// tb_id_ex_alu_feed
//
// Self-checking bench for id_ex_alu_feed.
//
// The bench keeps a reference copy of "the instruction currently in EX",
// plus an expected bubble count. Every cycle it predicts the outputs from
// that copy and from the forwarding inputs, working directly from the
// pipeline rules.
//
// The run has two phases:
//   - Directed scenarios for the main behaviours.
//   - A long randomized run.
// ---------------------------------------------------------------------------
module tb_id_ex_alu_feed;

    localparam int XLEN = 64;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic [RW-1:0]   id_rs1, id_rs2, id_rd;
    logic [1:0]      id_alu_op;
    logic [2:0]      id_funct3;
    logic            id_funct7_b5, id_alu_src, id_reg_write, id_mem_read;
    logic            id_mem_write, id_mem_to_reg, id_branch;
    logic            stall_in, flush;
    logic            exmem_reg_write, memwb_reg_write;
    logic [RW-1:0]   exmem_rd, memwb_rd;
    logic [XLEN-1:0] exmem_result, memwb_result;
    logic [XLEN-1:0] alu_a, alu_b, ex_store_data;
    logic [3:0]      alu_operation;
    logic            ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic            ex_mem_to_reg, ex_branch, hazard_stall;
    logic [RW-1:0]   ex_rd;
    logic [31:0]     stall_count;

    always #5 clk = ~clk;

    id_ex_alu_feed #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_funct3(id_funct3), .id_funct7_b5(id_funct7_b5),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .stall_in(stall_in), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
        .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_rd(ex_rd),
        .hazard_stall(hazard_stall), .stall_count(stall_count)
    );

    // Reference copy of the instruction currently held in EX.
    typedef struct packed {
        logic            valid, regWrite, memRead, memWrite, memToReg, branch, aluSrc;
        logic [1:0]      aluOp;
        logic [2:0]      funct3;
        logic            b5;
        logic [RW-1:0]   rs1, rs2, rd;
        logic [XLEN-1:0] rs1Data, rs2Data, imm;
    } instr_t;

    instr_t      exModel;
    logic [31:0] countModel;
    int          testsRun    = 0;
    int          testsFailed = 0;

    // Single comparison point: counts each check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // ALU opcode table, written from the instruction semantics.
    function automatic logic [3:0] refAluCode(input logic [1:0] op,
                                              input logic [2:0] f3,
                                              input logic b5);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (f3 == 3'b000) return (op == 2'b10 && b5) ? 4'b0110 : 4'b0010;
        if (f3 == 3'b111) return 4'b0000;
        if (f3 == 3'b110) return 4'b0001;
        if (f3 == 3'b001) return 4'b1000;
        return 4'b1111;
    endfunction

    // The newest writer wins; x0 never receives a forwarded value.
    function automatic logic [XLEN-1:0] refForward(input logic [RW-1:0] rs,
                                                   input logic [XLEN-1:0] regVal);
        if (rs == 0) return regVal;
        if (exmem_reg_write && exmem_rd == rs) return exmem_result;
        if (memwb_reg_write && memwb_rd == rs) return memwb_result;
        return regVal;
    endfunction

    // A load in EX feeds a register that the ID instruction reads.
    function automatic logic refHazard();
        logic readsRs2;
        if (stall_in || !id_valid || !exModel.valid || !exModel.memRead) return 1'b0;
        if (exModel.rd == 0) return 1'b0;
        readsRs2 = !id_alu_src;
        return (exModel.rd == id_rs1) || (readsRs2 && exModel.rd == id_rs2);
    endfunction

    // Compare every output against the model's prediction.
    task automatic compareAll();
        logic [XLEN-1:0] expA, expS, expB;
        expA = refForward(exModel.rs1, exModel.rs1Data);
        expS = refForward(exModel.rs2, exModel.rs2Data);
        expB = exModel.aluSrc ? exModel.imm : expS;
        checkOutput("hazard_stall", 64'(hazard_stall), 64'(refHazard()));
        checkOutput("alu_a", alu_a, expA);
        checkOutput("alu_b", alu_b, expB);
        checkOutput("ex_store_data", ex_store_data, expS);
        checkOutput("alu_operation", 64'(alu_operation),
                    64'(refAluCode(exModel.aluOp, exModel.funct3, exModel.b5)));
        checkOutput("ex_ctrl",
                    64'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}),
                    64'({exModel.valid, exModel.regWrite, exModel.memRead, exModel.memWrite,
                         exModel.memToReg, exModel.branch}));
        checkOutput("ex_rd", 64'(ex_rd), 64'(exModel.rd));
        checkOutput("stall_count", 64'(stall_count), 64'(countModel));
    endtask

    // Advance the model across one clock edge.
    task automatic updateModel();
        logic hz;
        instr_t nxt;
        hz = refHazard();
        nxt = '{valid: id_valid, regWrite: id_reg_write, memRead: id_mem_read,
                memWrite: id_mem_write, memToReg: id_mem_to_reg, branch: id_branch,
                aluSrc: id_alu_src, aluOp: id_alu_op, funct3: id_funct3, b5: id_funct7_b5,
                rs1: id_rs1, rs2: id_rs2, rd: id_rd, rs1Data: id_rs1_data,
                rs2Data: id_rs2_data, imm: id_imm};
        if (reset) begin
            exModel    = '0;
            countModel = '0;
        end else if (flush) begin
            exModel = '0;
        end else if (stall_in) begin
            exModel = exModel;
        end else if (hz) begin
            exModel = '0;
`ifdef ID_EX_STALL_CNT_EN
            countModel = countModel + 32'd1;
`endif
        end else begin
            exModel = nxt;
        end
    endtask

    // One clock cycle: check on the falling edge, advance on the rising
    // edge, then return 1 time unit after that edge.
    task automatic cycle();
        @(negedge clk);
        compareAll();
        @(posedge clk);
        updateModel();
        #1;
    endtask

    task automatic clearInputs();
        id_valid = 0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alu_op = '0; id_funct3 = '0;
        id_funct7_b5 = 0; id_alu_src = 0; id_reg_write = 0; id_mem_read = 0;
        id_mem_write = 0; id_mem_to_reg = 0; id_branch = 0;
        stall_in = 0; flush = 0;
        exmem_reg_write = 0; memwb_reg_write = 0; exmem_rd = '0; memwb_rd = '0;
        exmem_result = '0; memwb_result = '0;
    endtask

    task automatic loadInstr(input logic [RW-1:0] rs1, input logic [XLEN-1:0] d1,
                             input logic [RW-1:0] rs2, input logic [XLEN-1:0] d2,
                             input logic [RW-1:0] rd, input logic [XLEN-1:0] imm,
                             input logic [1:0] op, input logic [2:0] f3, input logic b5,
                             input logic src, input logic memRd);
        id_valid = 1; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
        id_rd = rd; id_imm = imm; id_alu_op = op; id_funct3 = f3; id_funct7_b5 = b5;
        id_alu_src = src; id_reg_write = 1; id_mem_read = memRd; id_mem_to_reg = memRd;
        id_mem_write = 0; id_branch = 0;
    endtask

    // Randomized drive. Register indices are kept small so that forwarding
    // and hazard matches happen often.
    task automatic applyStimulus();
        reset           = ($urandom_range(0, 99) < 2);
        flush           = ($urandom_range(0, 99) < 6);
        stall_in        = ($urandom_range(0, 99) < 10);
        id_valid        = ($urandom_range(0, 99) < 80);
        id_rs1          = 5'($urandom_range(0, 7));
        id_rs2          = 5'($urandom_range(0, 7));
        id_rd           = 5'($urandom_range(0, 7));
        id_rs1_data     = {$urandom(), $urandom()};
        id_rs2_data     = {$urandom(), $urandom()};
        id_imm          = {$urandom(), $urandom()};
        id_alu_op       = 2'($urandom_range(0, 3));
        id_funct3       = 3'($urandom_range(0, 7));
        id_funct7_b5    = 1'($urandom_range(0, 1));
        id_alu_src      = 1'($urandom_range(0, 1));
        id_reg_write    = 1'($urandom_range(0, 1));
        id_mem_read     = ($urandom_range(0, 99) < 35);
        id_mem_write    = 1'($urandom_range(0, 1));
        id_mem_to_reg   = 1'($urandom_range(0, 1));
        id_branch       = 1'($urandom_range(0, 1));
        exmem_reg_write = 1'($urandom_range(0, 1));
        memwb_reg_write = 1'($urandom_range(0, 1));
        exmem_rd        = 5'($urandom_range(0, 7));
        memwb_rd        = 5'($urandom_range(0, 7));
        exmem_result    = {$urandom(), $urandom()};
        memwb_result    = {$urandom(), $urandom()};
    endtask

    logic [31:0] countBefore;

    // Main sequence: directed scenarios first, then random traffic.
    initial begin
        clearInputs();
        reset      = 1;
        exModel    = '0;
        countModel = '0;
        @(posedge clk);
        updateModel();
        #1;
        cycle();
        reset = 0;

        // Reset then idle.
        cycle();
        checkOutput("idle_valid", 64'(ex_valid), 64'd0);
        checkOutput("idle_op", 64'(alu_operation), 64'b0010);
        checkOutput("idle_a", alu_a, 64'd0);
        checkOutput("idle_b", alu_b, 64'd0);
        checkOutput("idle_hz", 64'(hazard_stall), 64'd0);

        // R-type SUB.
        loadInstr(5'd1, 64'd100, 5'd2, 64'd30, 5'd3, 64'd0, 2'b10, 3'b000, 1'b1, 1'b0, 1'b0);
        cycle();
        clearInputs();
        checkOutput("sub_a", alu_a, 64'd100);
        checkOutput("sub_b", alu_b, 64'd30);
        checkOutput("sub_op", 64'(alu_operation), 64'b0110);
        cycle();

        // Forwarding priority: x5 in EX, held there by stall_in.
        loadInstr(5'd5, 64'h11, 5'd6, 64'h22, 5'd9, 64'd0, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0);
        cycle();
        clearInputs();
        stall_in = 1;
        exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 64'hAA;
        memwb_reg_write = 1; memwb_rd = 5'd5; memwb_result = 64'hBB;
        #1 checkOutput("fwd_exmem", alu_a, 64'hAA);
        cycle();
        exmem_reg_write = 0;
        #1 checkOutput("fwd_memwb", alu_a, 64'hBB);
        cycle();
        stall_in = 0;
        loadInstr(5'd0, 64'h33, 5'd0, 64'h44, 5'd1, 64'd0, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0);
        exmem_reg_write = 1; exmem_rd = 5'd0;
        memwb_reg_write = 1; memwb_rd = 5'd0;
        cycle();
        checkOutput("fwd_x0", alu_a, 64'h33);
        clearInputs();
        cycle();

        // Load-use: ld x7 in EX, then add x8, x7, x1 in ID.
        countBefore = stall_count;
        loadInstr(5'd2, 64'h1000, 5'd0, 64'd0, 5'd7, 64'd8, 2'b00, 3'b011, 1'b0, 1'b1, 1'b1);
        cycle();
        loadInstr(5'd7, 64'hDEAD, 5'd1, 64'h5, 5'd8, 64'd0, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0);
        #1 checkOutput("lu_hz_on", 64'(hazard_stall), 64'd1);
        cycle();
        checkOutput("lu_bubble", 64'(ex_valid), 64'd0);
        checkOutput("lu_hz_off", 64'(hazard_stall), 64'd0);
        memwb_reg_write = 1; memwb_rd = 5'd7; memwb_result = 64'h77;
        cycle();
        checkOutput("lu_fwd", alu_a, 64'h77);
`ifdef ID_EX_STALL_CNT_EN
        checkOutput("lu_count", 64'(stall_count), 64'(countBefore + 32'd1));
`else
        checkOutput("lu_count", 64'(stall_count), 64'd0);
`endif
        clearInputs();
        cycle();

        // stall_in with a dependent ID held back, then flush during stall.
        loadInstr(5'd3, 64'h9, 5'd0, 64'd0, 5'd4, 64'd16, 2'b00, 3'b011, 1'b0, 1'b1, 1'b1);
        cycle();
        loadInstr(5'd4, 64'h1, 5'd4, 64'h2, 5'd5, 64'd0, 2'b10, 3'b111, 1'b0, 1'b0, 1'b0);
        stall_in = 1;
        for (int i = 0; i < 3; i++) cycle();
        checkOutput("stall_hold_rd", 64'(ex_rd), 64'd4);
        flush = 1;
        cycle();
        checkOutput("flush_stall", 64'(ex_valid), 64'd0);
        clearInputs();

        // Flush together with a hazard: the stall still holds ID.
        loadInstr(5'd3, 64'h9, 5'd0, 64'd0, 5'd4, 64'd16, 2'b00, 3'b011, 1'b0, 1'b1, 1'b1);
        cycle();
        loadInstr(5'd4, 64'h1, 5'd2, 64'h2, 5'd5, 64'd0, 2'b10, 3'b110, 1'b0, 1'b0, 1'b0);
        flush = 1;
        cycle();
        flush = 0;
        cycle();
        clearInputs();

        // SLLI, then an illegal R-type encoding.
        loadInstr(5'd1, 64'h3, 5'd0, 64'd0, 5'd2, 64'd4, 2'b11, 3'b001, 1'b0, 1'b1, 1'b0);
        cycle();
        checkOutput("slli_op", 64'(alu_operation), 64'b1000);
        checkOutput("slli_b", alu_b, 64'd4);
        loadInstr(5'd1, 64'h3, 5'd2, 64'h6, 5'd2, 64'd0, 2'b10, 3'b010, 1'b0, 1'b0, 1'b0);
        cycle();
        checkOutput("illegal_op", 64'(alu_operation), 64'b1111);
        clearInputs();
        cycle();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/id_ex_alu_feed.md
Name: id_ex_alu_feed

Overview:
- ID/EX pipeline register plus operand-select logic directly upstream of the 64-bit ALU in the RISC-V 5-stage pipeline.
- Captures decoded operands and controls from ID, forwards results from EX/MEM and MEM/WB, and produces the ALU inputs `alu_a`, `alu_b` and the 4-bit `alu_operation`.
- Detects load-use hazards and inserts bubbles.

Parameters:
- XLEN, 64, datapath width; must match ALU width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs1_data, id_rs2_data, id_imm  in  XLEN  register-file read data, sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  register indices.
- id_alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- id_funct3  in  3  instr[14:12].
- id_funct7_b5  in  1  instr[30].
- id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  decoded controls.
- stall_in  in  1  global pipeline hold.
- flush  in  1  branch-taken squash of EX.
- exmem_reg_write, memwb_reg_write  in  1  writer valid.
- exmem_rd, memwb_rd  in  REG_ADDR_W  writer index.
- exmem_result, memwb_result  in  XLEN  writer data.
- alu_a, alu_b  out  XLEN  ALU operands.
- alu_operation  out  4  ALU opcode.
- ex_store_data  out  XLEN  forwarded rs2 for stores.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  registered controls.
- ex_rd  out  REG_ADDR_W  registered destination.
- hazard_stall  out  1  holds PC and IF/ID.
- stall_count  out  32  bubble counter; see Optional Feature.

Behaviour:
- Stage register update priority, evaluated on each clk edge:
  - reset: all ex_* registers, stored operands, immediate, indices and funct fields cleared to 0.
  - flush: same clear as reset, i.e. a bubble.
  - stall_in: hold all registers.
  - hazard_stall: load a bubble, with all ex_* controls and ex_valid = 0.
  - otherwise: load all id_* fields; ex_valid <= id_valid.
- Reset, flush and bubble leave `alu_operation` = 0010 (ADD of 0+0) and `ex_reg_write` = 0.
- hazard_stall is combinational:
  - asserted when ex_valid & ex_mem_read & ex_rd != 0 & id_valid & (ex_rd == id_rs1 | (ex_rd == id_rs2 & !id_alu_src));
  - forced to 0 while stall_in is high.
- Latency: ID inputs appear at the outputs 1 cycle after the loading edge; there is no additional stage.
- Forwarding is combinational from the registered rs1/rs2 and their data, per operand:
  - EX/MEM first: if exmem_reg_write & exmem_rd != 0 & exmem_rd == ex_rsN, use exmem_result;
  - else MEM/WB: same test with memwb_*, use memwb_result;
  - else the registered read data.
  - Register x0 is never forwarded.
- Operand select:
  - alu_a = forwarded rs1.
  - alu_b = ex_alu_src ? ex_imm : forwarded rs2.
  - ex_store_data = forwarded rs2, always.
- ALU control decode from registered fields:
  - alu_op 00 -> 0010 (ADD).
  - alu_op 01 -> 0110 (SUB).
  - alu_op 10, by funct3/b5:
    - 000/0 -> 0010
    - 000/1 -> 0110
    - 111 -> 0000
    - 110 -> 0001
    - 001 -> 1000 (SLL)
  - alu_op 11, by funct3: 000 -> 0010; 111 -> 0000; 110 -> 0001; 001 -> 1000.
  - Any other combination -> 1111, for which the ALU returns 0.
- Reset during stall: reset wins and the stage is empty on the next cycle.
- Flush together with hazard_stall: flush takes effect and hazard_stall still holds ID for that cycle.

Optional Feature:
- Macro `ID_EX_STALL_CNT_EN`.
- When defined: stall_count is a 32-bit register.
  - Cleared on reset.
  - Increments by 1 on each edge where a hazard bubble is loaded.
  - Wraps from 0xFFFFFFFF to 0.
  - Flush-induced bubbles are not counted.
- When undefined: stall_count is tied to 0 and no counter logic is built.

Test Plan:
- Reset then idle: after reset is released, ex_valid = 0, alu_a = alu_b = 0, alu_operation = 0010, hazard_stall = 0.
- R-type SUB: load rs1 = 100, rs2 = 30, alu_op 10, funct3 000, b5 = 1 -> next cycle alu_a = 100, alu_b = 30, alu_operation = 0110.
- Forwarding priority: EX has rs1 = x5, with exmem_rd = 5 / result 0xAA and memwb_rd = 5 / result 0xBB, both write-enabled -> alu_a = 0xAA. Dropping exmem_reg_write -> alu_a = 0xBB. With rd = 0, no forwarding occurs.
- Load-use: ld x7 sits in EX, add x8, x7, x1 sits in ID -> hazard_stall = 1 for exactly 1 cycle, one bubble enters EX, the add then executes with x7 forwarded from MEM/WB; stall_count increments by 1.
- stall_in and flush: stall_in = 1 for 3 cycles -> outputs unchanged and hazard_stall = 0. flush = 1 together with stall_in -> ex_valid = 0 on the next edge.
- SLLI and illegal encodings: alu_op 11, funct3 001, imm 4 -> alu_operation = 1000, alu_b = 4. alu_op 10, funct3 010 -> 1111.
